// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: decoder control encodings, the
// control bundle carried down the pipe, and the all-zero bubble value.
package id_ex_stage_pkg;

  localparam int CTRL2_W = 2;

  typedef enum logic [CTRL2_W-1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } regdst_e;

  typedef enum logic [CTRL2_W-1:0] {
    REGSRC_ALU = 2'd0,
    REGSRC_MEM = 2'd1,
    REGSRC_PC4 = 2'd2
  } regsrc_e;

  typedef enum logic [CTRL2_W-1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } aluop_e;

  typedef enum logic [CTRL2_W-1:0] {
    PCSRC_PC4    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JR     = 2'd3
  } pcsrc_e;

  typedef struct packed {
    logic [CTRL2_W-1:0] regDst;
    logic [CTRL2_W-1:0] regSrc;
    logic [CTRL2_W-1:0] ALUOp;
    logic               ALUSrc;
    logic               regWrite;
    logic               memWrite;
    logic               memRead;
  } ctrl_t;

  // A bubble never writes a register or touches memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the load sitting in EX produces a register that
// the instruction in ID wants to read. Register 0 never creates a dependency.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu_hazard
);

  assign lu_hazard = ex_memRead && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, PC/IF-ID freeze,
// branch-redirect gating during stalls, and saturating stall/bubble counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic [1:0]        id_regDst,
  input  logic [1:0]        id_regSrc,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic              id_regWrite,
  input  logic              id_memWrite,
  input  logic              id_memRead,
  input  logic              id_flush,
  input  logic [1:0]        id_pcSrc,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  output logic [1:0]        ex_regDst,
  output logic [1:0]        ex_regSrc,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_regWrite,
  output logic              ex_memWrite,
  output logic              ex_memRead,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              flush_out,
  output logic [1:0]        pcSrc_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  lu_hazard;
  logic  stall;

  assign id_ctrl = '{regDst:   id_regDst,
                     regSrc:   id_regSrc,
                     ALUOp:    id_ALUOp,
                     ALUSrc:   id_ALUSrc,
                     regWrite: id_regWrite,
                     memWrite: id_memWrite,
                     memRead:  id_memRead};

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_memRead (ex_ctrl.memRead),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu_hazard  (lu_hazard)
  );

  assign stall      = lu_hazard | ext_stall;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  // A branch resolved in ID while stalled would use stale operands, so the redirect waits.
  assign flush_out = id_flush & ~stall;
  assign pcSrc_out = stall ? CTRL2_W'(PCSRC_PC4) : id_pcSrc;

  // External hold beats the hazard; a hazard only zeroes control, data still flows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_pc4  <= '0;
      ex_rd1  <= '0;
      ex_rd2  <= '0;
      ex_imm  <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else if (!ext_stall) begin
      ex_ctrl <= lu_hazard ? CTRL_BUBBLE : id_ctrl;
      ex_pc4  <= id_pc4;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (lu_hazard && !ext_stall && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_regDst   = ex_ctrl.regDst;
  assign ex_regSrc   = ex_ctrl.regSrc;
  assign ex_ALUOp    = ex_ctrl.ALUOp;
  assign ex_ALUSrc   = ex_ctrl.ALUSrc;
  assign ex_regWrite = ex_ctrl.regWrite;
  assign ex_memWrite = ex_ctrl.memWrite;
  assign ex_memRead  = ex_ctrl.memRead;

endmodule
